rx_bit_timer: RTL and testbench
===============================

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, clock cycles per serial bit; legal range 4..16.
REQ-002 Parameter SAMPLE_POINT, default 3, counter value at which the line is sampled; legal range 2..CLKS_PER_BIT-2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, synchronous and active-low.
REQ-005 serial_in  input  1  synchronized serial line level, idle 1.
REQ-006 edge_detected  input  1  one-cycle pulse from the edge detector on any line transition.
REQ-007 enable  input  1  receive-window qualifier from the RX controller; block idle when 0.
REQ-008 shift_enable  output  1  one-cycle pulse; bit_out is valid for shifting into the RX shift register.
REQ-009 bit_out  output  1  NRZI-decoded data bit, held between shift_enable pulses.
REQ-010 byte_done  output  1  one-cycle pulse coincident with every 8th shift_enable since enable rose.
REQ-011 stuff_err  output  1  one-cycle pulse on a bit-stuffing violation.

Function
REQ-012 The bit counter cnt (4 bits) SHALL clear to 0 in any cycle where enable=0.
REQ-013 With enable=1 and edge_detected=1, cnt SHALL load 1, so the edge cycle counts as count 0 (resync).
REQ-014 With enable=1 and edge_detected=0, cnt SHALL increment and wrap from CLKS_PER_BIT-1 to 0.
REQ-015 A sample event SHALL occur in a cycle with enable=1, edge_detected=0 and cnt==SAMPLE_POINT; edge_detected=1 in that cycle suppresses the event.
REQ-016 On a sample event: decoded = (serial_in == prev_level); prev_level loads serial_in.
REQ-017 prev_level SHALL be 1 whenever enable=0.
REQ-018 Ones counter ones_cnt (3 bits) SHALL track consecutive decoded 1s among delivered bits.
REQ-019 Sample event with ones_cnt<6: deliver the bit; ones_cnt becomes ones_cnt+1 if decoded=1, else 0.
REQ-020 Sample event with ones_cnt==6 and decoded=0: stuffed bit; SHALL not be delivered; ones_cnt cleared.
REQ-021 Sample event with ones_cnt==6 and decoded=1: stuff_err SHALL pulse; the bit is not delivered; ones_cnt cleared.
REQ-022 Delivery SHALL increment bit_cnt (3 bits, wrapping 7->0); byte_done pulses with the delivery that wraps it.
REQ-023 All outputs SHALL be registered; the response to a sample event in cycle N appears in cycle N+1 only.
REQ-024 shift_enable, byte_done and stuff_err SHALL be 0 in every cycle not following a qualifying sample event.
REQ-025 bit_out SHALL update only with shift_enable and hold its value otherwise.
REQ-026 A sample event in the last cycle before enable falls SHALL still produce its cycle-N+1 output.
REQ-027 enable=0 SHALL clear ones_cnt and bit_cnt, so a dropped window discards any partial byte.
REQ-028 edge_detected SHALL be ignored while enable=0.

Reset
REQ-029 n_rst=0 at a rising clk edge SHALL set cnt=0, ones_cnt=0, bit_cnt=0 and prev_level=1.
REQ-030 n_rst=0 at a rising clk edge SHALL set shift_enable=0, byte_done=0, stuff_err=0 and bit_out=1.
REQ-031 Reset SHALL override enable and edge_detected, including mid-bit and mid-byte.

Verification (CLKS_PER_BIT=8, SAMPLE_POINT=3, enable rises at cycle 0)
REQ-032 Reset: n_rst=0 for 2 cycles while enable=1 and edges toggle -> all pulses 0, bit_out=1 for both cycles and the cycle after.
REQ-033 Idle line held 1 with no edges:
- shift_enable with bit_out=1 at cycles 4, 12, 20, 28, 36, 44;
- stuff_err pulses at cycle 52 with no shift_enable;
- shift_enable resumes at 60.
REQ-034 Sync pattern (line 0,1,0,1,0,1,0,0 per bit, edges at bit starts) -> decoded bits 0,0,0,0,0,0,0,1; byte_done coincides with the 8th shift_enable.
REQ-035 Resync: edge arrives at cycle 10 instead of 8 -> cnt=1 at cycle 11; sample at cycle 13; shift_enable at 14; no pulse at 12.
REQ-036 Stuffing: six decoded 1s, then a 0, then a 1:
- six shift_enable pulses;
- no pulse for the stuffed 0;
- next pulse carries bit_out=1;
- stuff_err stays 0.
REQ-037 Abort: enable dropped after 5 delivered bits, re-raised 3 cycles later -> byte_done first pulses on the 8th delivery after re-enable; prev_level restarts at 1.

Source files
------------

// File: rtl/rx_bit_timer.sv
// Receive bit timer: times bit cells, NRZI-decodes the sampled line, removes
// stuffed bits and flags stuffing violations and byte boundaries.
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic serial_in,
   input  logic edge_detected,
   input  logic enable,
   output logic shift_enable,
   output logic bit_out,
   output logic byte_done,
   output logic stuff_err
);

   localparam logic [3:0] CNT_LAST   = 4'(CLKS_PER_BIT - 1);
   localparam logic [3:0] CNT_SAMPLE = 4'(SAMPLE_POINT);
   localparam logic [2:0] ONES_MAX   = 3'd6;

   logic [3:0] cnt_q, cnt_d;
   logic       prev_level_q, prev_level_d;
   logic [2:0] ones_cnt_q, ones_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       shift_enable_q, shift_enable_d;
   logic       bit_out_q, bit_out_d;
   logic       byte_done_q, byte_done_d;
   logic       stuff_err_q, stuff_err_d;

   logic       sample_event;
   logic       decoded;

   assign sample_event = enable && !edge_detected && (cnt_q == CNT_SAMPLE);
   assign decoded      = (serial_in == prev_level_q);

   // Bit-cell counter; an edge restarts the cell so the edge cycle is count 0.
   always_comb begin
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = 4'd0;
      end else if (edge_detected) begin
         cnt_d = 4'd1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = 4'd0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_comb begin
      prev_level_d   = prev_level_q;
      ones_cnt_d     = ones_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shift_enable_d = 1'b0;
      byte_done_d    = 1'b0;
      stuff_err_d    = 1'b0;
      bit_out_d      = bit_out_q;
      if (sample_event) begin
         prev_level_d = serial_in;
         if (ones_cnt_q == ONES_MAX) begin
            // Seventh bit after six ones: a 0 is stuffing, a 1 is a violation.
            ones_cnt_d  = 3'd0;
            stuff_err_d = decoded;
         end else begin
            shift_enable_d = 1'b1;
            bit_out_d      = decoded;
            ones_cnt_d     = decoded ? (ones_cnt_q + 3'd1) : 3'd0;
            bit_cnt_d      = bit_cnt_q + 3'd1;
            byte_done_d    = (bit_cnt_q == 3'd7);
         end
      end
      // Closing the window drops any partial byte and restarts NRZI at idle.
      if (!enable) begin
         prev_level_d = 1'b1;
         ones_cnt_d   = 3'd0;
         bit_cnt_d    = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q          <= 4'd0;
         prev_level_q   <= 1'b1;
         ones_cnt_q     <= 3'd0;
         bit_cnt_q      <= 3'd0;
         shift_enable_q <= 1'b0;
         bit_out_q      <= 1'b1;
         byte_done_q    <= 1'b0;
         stuff_err_q    <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         prev_level_q   <= prev_level_d;
         ones_cnt_q     <= ones_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_enable_q <= shift_enable_d;
         bit_out_q      <= bit_out_d;
         byte_done_q    <= byte_done_d;
         stuff_err_q    <= stuff_err_d;
      end
   end

   assign shift_enable = shift_enable_q;
   assign bit_out      = bit_out_q;
   assign byte_done    = byte_done_q;
   assign stuff_err    = stuff_err_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Directed bench for rx_bit_timer: expected output events are queued per test
// and compared cycle by cycle against the registered outputs.
module tb_rx_bit_timer;

   logic clk = 1'b0;
   logic n_rst, serial_in, edge_detected, enable;
   logic shift_enable, bit_out, byte_done, stuff_err;

   rx_bit_timer #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .serial_in(serial_in),
      .edge_detected(edge_detected),
      .enable(enable),
      .shift_enable(shift_enable),
      .bit_out(bit_out),
      .byte_done(byte_done),
      .stuff_err(stuff_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic se;
      logic bd;
      logic err;
      logic bo;
   } ev_t;

   ev_t   q[$];
   int    cyc;
   int    checks;
   int    fails;
   logic  exp_bo;
   string tag;

   function automatic void push(input int c, input logic se, input logic bd,
                                input logic err, input logic bo);
      ev_t e;
      e.cyc = c; e.se = se; e.bd = bd; e.err = err; e.bo = bo;
      q.push_back(e);
   endfunction

   // Advance one clock; outputs seen afterwards belong to the new cycle.
   task automatic tick();
      logic [3:0] obs, expv;
      ev_t e;
      @(posedge clk);
      #1;
      cyc++;
      obs = {shift_enable, byte_done, stuff_err, bit_out};
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         expv = {e.se, e.bd, e.err, e.bo};
         exp_bo = e.bo;
      end else begin
         expv = {3'b000, exp_bo};
      end
      checks++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s cyc=%0d {se,bd,err,bo} got=%b exp=%b", tag, cyc, obs, expv);
      end
      $display("[TB] %s cyc=%0d se=%b bd=%b err=%b bo=%b", tag, cyc,
               shift_enable, byte_done, stuff_err, bit_out);
   endtask

   task automatic drive_bit(input logic lvl, input logic edg, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         serial_in     = lvl;
         edge_detected = (i == 0) ? edg : 1'b0;
         tick();
      end
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         enable = 1'b0; serial_in = 1'b1; edge_detected = 1'b0;
         tick();
      end
   endtask

   initial begin
      logic [7:0] lv;
      logic       last;
      checks = 0; fails = 0; cyc = 0; exp_bo = 1'b1;
      n_rst = 1'b0; enable = 1'b1; serial_in = 1'b0; edge_detected = 1'b1;

      // Reset overrides enable and toggling edges.
      tag = "reset";
      tick();
      edge_detected = 1'b0; serial_in = 1'b1;
      tick();
      n_rst = 1'b1; enable = 1'b0;
      tick();
      gap(2);

      // Idle line: six ones, stuffing violation, then delivery resumes.
      tag = "idle";
      for (int k = 0; k < 6; k++) push(4 + 8 * k, 1, 0, 0, 1);
      push(52, 0, 0, 1, 1);
      push(60, 1, 0, 0, 1);
      cyc = 0; enable = 1'b1;
      drive_bit(1'b1, 1'b0, 62);
      gap(3);

      // Sync pattern.
      tag = "sync";
      lv = 8'b0010_1010;  // bit k = lv[k]: 0,1,0,1,0,1,0,0
      for (int k = 0; k < 8; k++) push(4 + 8 * k, 1, (k == 7), 0, (k == 7));
      cyc = 0; enable = 1'b1; last = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive_bit(lv[k], lv[k] != last, 8);
         last = lv[k];
      end
      gap(3);

      // Resync: late edge at cycle 10 moves the sample to cycle 13.
      tag = "resync";
      push(4, 1, 0, 0, 0);
      push(14, 1, 0, 0, 0);
      cyc = 0; enable = 1'b1;
      drive_bit(1'b0, 1'b1, 10);
      drive_bit(1'b1, 1'b1, 6);
      gap(3);

      // Stuffing: six ones, stuffed zero, a one, then a zero sampled just
      // before enable falls (8th delivery -> byte_done).
      tag = "stuff";
      for (int k = 0; k < 6; k++) push(4 + 8 * k, 1, 0, 0, 1);
      push(60, 1, 0, 0, 1);
      push(68, 1, 1, 0, 0);
      cyc = 0; enable = 1'b1;
      drive_bit(1'b1, 1'b0, 48);
      drive_bit(1'b0, 1'b1, 8);
      drive_bit(1'b0, 1'b0, 8);
      drive_bit(1'b1, 1'b1, 4);
      gap(3);

      // Abort after five deliveries, re-enable three cycles later.
      tag = "abort";
      push(4, 1, 0, 0, 0);
      for (int k = 1; k < 5; k++) push(4 + 8 * k, 1, 0, 0, 1);
      for (int k = 0; k < 8; k++) push(44 + 8 * k, 1, (k == 7), 0, k[0]);
      cyc = 0; enable = 1'b1;
      drive_bit(1'b0, 1'b1, 8);
      drive_bit(1'b0, 1'b0, 29);
      for (int i = 0; i < 3; i++) begin
         enable = 1'b0; serial_in = 1'b0; edge_detected = 1'b1;
         tick();
      end
      enable = 1'b1;
      lv = 8'b1100_1100;  // bit k = lv[k]: 0,0,1,1,0,0,1,1
      last = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive_bit(lv[k], lv[k] != last, 8);
         last = lv[k];
      end
      gap(3);

      // Reset mid-byte while enabled; counters and prev_level restart.
      tag = "rst_mid";
      push(4, 1, 0, 0, 0);
      push(12, 1, 0, 0, 0);
      push(15, 0, 0, 0, 1);
      push(19, 1, 0, 0, 1);
      cyc = 0; enable = 1'b1;
      drive_bit(1'b0, 1'b1, 8);
      drive_bit(1'b1, 1'b1, 6);
      n_rst = 1'b0; serial_in = 1'b1; edge_detected = 1'b1;
      tick();
      n_rst = 1'b1;
      drive_bit(1'b1, 1'b0, 5);
      gap(2);

      tag = "drain";
      checks++;
      assert (q.size() == 0)
      else begin
         fails++;
         $error("FAIL %s pending_events got=%0d exp=0", tag, q.size());
      end

      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

endmodule
